// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with registered sync/blank/strobe outputs.
// Latency: 1 vgaclk from the internal (div, h, v) state to every output pin.
// Backpressure: none; en low freezes the raster in place, restart zeroes it on the next edge.
//
// Ports:
//   vgaclk, reset_n          clock and asynchronous active-low reset
//   en, restart              advance enable / synchronous frame restart (restart wins)
//   hsync, vsync, sync_b     sync pins at HS_POL/VS_POL, composite sync active-low
//   blank_b, de              high inside the active area
//   x, y                     raw raster position, blanking included
//   pix_valid                first vgaclk of each pixel
//   line_start, frame_start  one-cycle strobes at (0, y) and (0, 0)
//   req_x, req_y, req_valid  position LEAD pixels ahead, and whether it is visible
module vga_timing_gen #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33,
    parameter int CW      = 10,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int PIX_DIV = 1,
    parameter int LEAD    = 0
) (
    input  logic          vgaclk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          restart,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_valid,
    output logic          line_start,
    output logic          frame_start,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          req_valid
);

    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;
    localparam int DW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    // Decode compares run one bit wider so that a boundary equal to 2**CW still fits.
    localparam int CX   = CW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(HMAX - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(VMAX - 1);
    localparam logic [CX-1:0] H_ACT    = CX'(HACTIVE);
    localparam logic [CX-1:0] V_ACT    = CX'(VACTIVE);
    localparam logic [CX-1:0] HS_BEG   = CX'(HACTIVE + HFP);
    localparam logic [CX-1:0] HS_END   = CX'(HACTIVE + HFP + HSYN);
    localparam logic [CX-1:0] VS_BEG   = CX'(VACTIVE + VFP);
    localparam logic [CX-1:0] VS_END   = CX'(VACTIVE + VFP + VSYN);
    localparam logic [CX-1:0] HMAX_X   = CX'(HMAX);
    localparam logic [CX-1:0] LEAD_X   = CX'(LEAD);

    logic [DW-1:0] div;
    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          pix_ce;

    assign pix_ce = en & (div == DIV_LAST);

    // Raster counters. restart takes priority over en so a frozen raster can still be rewound.
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (restart) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else if (en) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
            if (pix_ce) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    logic [CX-1:0] hx;
    logic [CX-1:0] vx;
    logic [CX-1:0] rh_sum;
    logic [CX-1:0] rh;
    logic [CW-1:0] rv;
    logic          hs_act;
    logic          vs_act;
    logic          act;
    logic          pv_d;
    logic          req_ok;

    always_comb begin
        hx     = {1'b0, h};
        vx     = {1'b0, v};
        hs_act = (hx >= HS_BEG) && (hx < HS_END);
        vs_act = (vx >= VS_BEG) && (vx < VS_END);
        act    = (hx < H_ACT) && (vx < V_ACT);
        pv_d   = en & (div == '0);

        // Look-ahead position; LEAD < HMAX so at most one line wrap is possible.
        rh_sum = hx + LEAD_X;
        rh     = rh_sum;
        rv     = v;
        if (rh_sum >= HMAX_X) begin
            rh = rh_sum - HMAX_X;
            rv = (v == V_LAST) ? '0 : v + 1'b1;
        end
        req_ok = (rh < H_ACT) && ({1'b0, rv} < V_ACT);
    end

    // Every pin comes straight from a flop so the DAC sees glitch-free levels.
    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            sync_b      <= 1'b1;
            blank_b     <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            req_valid   <= 1'b0;
        end else begin
            hsync       <= hs_act ? HS_POL : ~HS_POL;
            vsync       <= vs_act ? VS_POL : ~VS_POL;
            sync_b      <= ~(hs_act | vs_act);
            blank_b     <= act;
            de          <= act;
            x           <= h;
            y           <= v;
            pix_valid   <= pv_d;
            line_start  <= pv_d & (h == '0);
            frame_start <= pv_d & (h == '0) & (v == '0);
            req_x       <= rh[CW-1:0];
            req_y       <= rv;
            req_valid   <= req_ok;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of two small-raster vga_timing_gen instances.
// Raster A: 15x10 (8x6 active), PIX_DIV=1, active-low syncs, LEAD=4.
// Raster B: same geometry, PIX_DIV=2, active-high syncs, LEAD=0.
module tb_vga_timing_gen;

    logic vgaclk = 1'b0;
    always #5 vgaclk = ~vgaclk;

    logic reset_n, en, restart, en_b, restart_b;

    logic       a_hsync, a_vsync, a_sync_b, a_blank_b, a_de, a_pix_valid, a_line_start, a_frame_start;
    logic [4:0] a_x, a_y, a_req_x, a_req_y;
    logic       a_req_valid;
    logic       b_hsync, b_vsync, b_sync_b, b_blank_b, b_de, b_pix_valid, b_line_start, b_frame_start;
    logic [4:0] b_x, b_y, b_req_x, b_req_y;
    logic       b_req_valid;

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
        .VACTIVE(6), .VFP(1), .VSYN(2), .VBP(1),
        .CW(5), .HS_POL(1'b0), .VS_POL(1'b0), .PIX_DIV(1), .LEAD(4)
    ) dut_a (
        .vgaclk(vgaclk), .reset_n(reset_n), .en(en), .restart(restart),
        .hsync(a_hsync), .vsync(a_vsync), .sync_b(a_sync_b), .blank_b(a_blank_b), .de(a_de),
        .x(a_x), .y(a_y), .pix_valid(a_pix_valid), .line_start(a_line_start),
        .frame_start(a_frame_start), .req_x(a_req_x), .req_y(a_req_y), .req_valid(a_req_valid)
    );

    vga_timing_gen #(
        .HACTIVE(8), .HFP(2), .HSYN(3), .HBP(2),
        .VACTIVE(6), .VFP(1), .VSYN(2), .VBP(1),
        .CW(5), .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(2), .LEAD(0)
    ) dut_b (
        .vgaclk(vgaclk), .reset_n(reset_n), .en(en_b), .restart(restart_b),
        .hsync(b_hsync), .vsync(b_vsync), .sync_b(b_sync_b), .blank_b(b_blank_b), .de(b_de),
        .x(b_x), .y(b_y), .pix_valid(b_pix_valid), .line_start(b_line_start),
        .frame_start(b_frame_start), .req_x(b_req_x), .req_y(b_req_y), .req_valid(b_req_valid)
    );

    logic [28:0] a_pins, b_pins;
    assign a_pins = {a_x, a_y, a_req_x, a_req_y, a_req_valid, a_hsync, a_vsync, a_sync_b,
                     a_blank_b, a_de, a_pix_valid, a_line_start, a_frame_start};
    assign b_pins = {b_x, b_y, b_req_x, b_req_y, b_req_valid, b_hsync, b_vsync, b_sync_b,
                     b_blank_b, b_de, b_pix_valid, b_line_start, b_frame_start};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge vgaclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    function automatic logic [28:0] mk(input int x, y, rx, ry, rv, hs, vs, sb, de, pv, ls, fs);
        return {5'(x), 5'(y), 5'(rx), 5'(ry), 1'(rv), 1'(hs), 1'(vs), 1'(sb),
                1'(de), 1'(de), 1'(pv), 1'(ls), 1'(fs)};
    endfunction

    // Counts one frame starting at a negedge that shows frame_start; ends on the next frame_start.
    // "on" means the sync is at its active level for the selected raster.
    task automatic measure(input bit sel, output int len, de_n, ls_n, pv_n, hs_n, vs_n, hs_f, vs_f);
        int  idx;
        logic fs, d, l, p, hs, vs;
        idx = 0; len = -1; de_n = 0; ls_n = 0; pv_n = 0; hs_n = 0; vs_n = 0; hs_f = -1; vs_f = -1;
        while (len < 0 && idx < 700) begin
            if (sel) begin
                fs = b_frame_start; d = b_de; l = b_line_start; p = b_pix_valid; hs = b_hsync; vs = b_vsync;
            end else begin
                fs = a_frame_start; d = a_de; l = a_line_start; p = a_pix_valid; hs = ~a_hsync; vs = ~a_vsync;
            end
            if (idx > 0 && fs) begin
                len = idx;
            end else begin
                de_n += int'(d);
                ls_n += int'(l);
                pv_n += int'(p);
                if (hs) begin hs_n++; if (hs_f < 0) hs_f = idx; end
                if (vs) begin vs_n++; if (vs_f < 0) vs_f = idx; end
                @(negedge vgaclk);
                idx++;
            end
        end
    endtask

    typedef struct {
        int e;       // posedges after reset release
        int x, y;
        int rx, ry, rv;
        int hs, vs, de;
    } vec_t;

    vec_t tbl[19];
    int   cur_edge, n, t0, t1;
    int   len, de_n, ls_n, pv_n, hs_n, vs_n, hs_f, vs_f;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pixel index k shows up on the pins at edge k+1.  HS on h=10..12, VS on v=7..8,
        // visible h<8 & v<6, look-ahead h+4 wrapping at 15.
        tbl = '{
            '{  1,  0, 0,  4, 0, 1, 1, 1, 1 },
            '{  4,  3, 0,  7, 0, 1, 1, 1, 1 },
            '{  5,  4, 0,  8, 0, 0, 1, 1, 1 },
            '{  8,  7, 0, 11, 0, 0, 1, 1, 1 },
            '{  9,  8, 0, 12, 0, 0, 1, 1, 0 },
            '{ 11, 10, 0, 14, 0, 0, 0, 1, 0 },
            '{ 12, 11, 0,  0, 1, 1, 0, 1, 0 },
            '{ 13, 12, 0,  1, 1, 1, 0, 1, 0 },
            '{ 14, 13, 0,  2, 1, 1, 1, 1, 0 },
            '{ 15, 14, 0,  3, 1, 1, 1, 1, 0 },
            '{ 16,  0, 1,  4, 1, 1, 1, 1, 1 },
            '{ 83,  7, 5, 11, 5, 0, 1, 1, 1 },
            '{ 91,  0, 6,  4, 6, 0, 1, 1, 0 },
            '{116, 10, 7, 14, 7, 0, 0, 0, 0 },
            '{123,  2, 8,  6, 8, 0, 1, 0, 0 },
            '{136,  0, 9,  4, 9, 0, 1, 1, 0 },
            '{149, 13, 9,  2, 0, 1, 1, 1, 0 },
            '{150, 14, 9,  3, 0, 1, 1, 1, 0 },
            '{151,  0, 0,  4, 0, 1, 1, 1, 1 }
        };

        reset_n = 1'b0; en = 1'b1; restart = 1'b0; en_b = 1'b1; restart_b = 1'b0;
        repeat (3) @(negedge vgaclk);
        check("reset_a", a_pins, mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        check("reset_b", b_pins, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        reset_n  = 1'b1;
        cur_edge = 0;

        // Raster A position/decode vectors.
        for (int i = 0; i < 19; i++) begin
            while (cur_edge < tbl[i].e) begin
                @(posedge vgaclk);
                cur_edge++;
            end
            @(negedge vgaclk);
            check($sformatf("vec%0d", i), a_pins,
                  mk(tbl[i].x, tbl[i].y, tbl[i].rx, tbl[i].ry, tbl[i].rv, tbl[i].hs, tbl[i].vs,
                     tbl[i].hs & tbl[i].vs, tbl[i].de, 1, int'(tbl[i].x == 0),
                     int'(tbl[i].x == 0 && tbl[i].y == 0)));
        end

        // Full frame on A, starting from the frame_start just checked.
        measure(1'b0, len, de_n, ls_n, pv_n, hs_n, vs_n, hs_f, vs_f);
        check("a_frame_len", len, 150);
        check("a_de_count", de_n, 48);
        check("a_ls_count", ls_n, 10);
        check("a_pv_count", pv_n, 150);
        check("a_hs_low", hs_n, 30);
        check("a_vs_low", vs_n, 30);
        check("a_hs_first", hs_f, 10);
        check("a_vs_first", vs_f, 105);

        // Freeze: pins show x=5 while the counter already sits at 6, so 6 is the held value.
        n = 0;
        while (!a_line_start && n < 40) begin @(negedge vgaclk); n++; end
        check("wait_ls0", int'(n < 40), 1);
        t0 = cyc;
        n = 0;
        while (a_x != 5'd5 && n < 40) begin @(negedge vgaclk); n++; end
        check("wait_x5", int'(n < 40), 1);
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge vgaclk);
            check($sformatf("freeze%0d", k), {a_x, a_pix_valid, a_line_start, a_frame_start}, {5'd6, 3'b000});
        end
        en = 1'b1;
        @(negedge vgaclk);
        check("freeze_resume", {a_x, a_pix_valid}, {5'd6, 1'b1});
        n = 0;
        while (!a_line_start && n < 60) begin @(negedge vgaclk); n++; end
        t1 = cyc;
        check("freeze_line_period", t1 - t0, 22);

        // Restart at (3,2): one edge still shows the old raster, the second shows (0,0).
        n = 0;
        while (!(a_x == 5'd3 && a_y == 5'd2) && n < 200) begin @(negedge vgaclk); n++; end
        check("wait_x3y2", int'(n < 200), 1);
        restart = 1'b1;
        @(negedge vgaclk);
        check("restart_old", a_x, 4);
        restart = 1'b0;
        @(negedge vgaclk);
        check("restart_zero", {a_x, a_y, a_frame_start}, {5'd0, 5'd0, 1'b1});
        t0 = cyc;
        n = 0;
        do begin @(negedge vgaclk); n++; end while (!a_frame_start && n < 200);
        check("restart_period", cyc - t0, 150);

        // Restart while frozen: counters zero, strobes wait for en.
        en = 1'b0; restart = 1'b1;
        repeat (2) @(negedge vgaclk);
        restart = 1'b0;
        repeat (3) @(negedge vgaclk);
        check("hold_zero", {a_x, a_y, a_pix_valid, a_line_start, a_frame_start}, 13'd0);
        en = 1'b1;
        @(negedge vgaclk);
        check("hold_go", {a_x, a_y, a_pix_valid, a_line_start, a_frame_start}, {10'd0, 3'b111});
        @(negedge vgaclk);
        check("hold_next", a_x, 1);

        // Reset asserted mid hsync pulse clears the pins immediately.
        n = 0;
        while (a_x != 5'd11 && n < 40) begin @(negedge vgaclk); n++; end
        check("pre_reset_hs", a_hsync, 0);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_a", a_pins, mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        check("midreset_b", b_pins, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        @(negedge vgaclk);
        reset_n = 1'b1;

        // Raster B: each pixel spans two clocks, pix_valid on the first.
        for (int k = 0; k < 6; k++) begin
            @(negedge vgaclk);
            check($sformatf("b_div%0d", k), {b_x, b_pix_valid, b_frame_start},
                  {5'(k / 2), 1'(k % 2 == 0), 1'(k == 0)});
            if (k == 0)
                check("a_first_edge", a_pins, mk(0, 0, 4, 0, 1, 1, 1, 1, 1, 1, 1, 1));
        end
        n = 0;
        while (!b_frame_start && n < 400) begin @(negedge vgaclk); n++; end
        check("wait_b_fs", int'(n < 400), 1);
        measure(1'b1, len, de_n, ls_n, pv_n, hs_n, vs_n, hs_f, vs_f);
        check("b_frame_len", len, 300);
        check("b_de_count", de_n, 96);
        check("b_ls_count", ls_n, 10);
        check("b_pv_count", pv_n, 150);
        check("b_hs_high", hs_n, 60);
        check("b_vs_high", vs_n, 60);
        check("b_hs_first", hs_f, 20);
        check("b_vs_first", vs_f, 210);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of the team's fixed 640x480 sync/counter block. It adds configurable timing and counter width, selectable sync polarity, an integer pixel-clock divider, a freeze enable, a synchronous frame restart, registered glitch-free outputs, line/frame start strobes, and a look-ahead pixel request for fetch pipelines. It sits between the clock generator and the frame-buffer/pixel pipeline, driving the DAC sync and blank pins.

## Interface
- HACTIVE, 640, active pixels per line
- HFP, 16, horizontal front porch (pixels)
- HSYN, 96, hsync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- VACTIVE, 480, active lines
- VFP, 10, vertical front porch (lines)
- VSYN, 2, vsync width (lines)
- VBP, 33, vertical back porch (lines)
- CW, 10, counter and coordinate width; HMAX=HACTIVE+HFP+HSYN+HBP and VMAX=VACTIVE+VFP+VSYN+VBP must each be <= 2**CW
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIX_DIV, 1, vgaclk cycles per pixel (>= 1)
- LEAD, 0, request look-ahead in pixels (0 <= LEAD < HMAX)

Ports:
- vgaclk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  advance enable; low freezes all counters
- restart  in  1  synchronous frame restart
- hsync, vsync  out  1  sync at HS_POL / VS_POL active level
- sync_b  out  1  composite sync, active-low: low when either sync is active
- blank_b  out  1  high inside active area
- de  out  1  data enable; equal to blank_b
- x, y  out  CW  current pixel coordinates (raw counters, including blanking)
- pix_valid  out  1  high on the first vgaclk of each pixel
- line_start  out  1  one-cycle strobe at pixel (0, y)
- frame_start  out  1  one-cycle strobe at pixel (0, 0)
- req_x, req_y  out  CW  coordinates LEAD pixels ahead of x, y
- req_valid  out  1  req_x/req_y lie inside the active area

## Operation
- Internal state: div (0..PIX_DIV-1), h (0..HMAX-1), v (0..VMAX-1).
- pix_ce = en & (div == PIX_DIV-1).
- Each clock with en=1, div increments and wraps to 0 after PIX_DIV-1; PIX_DIV=1 keeps div=0.
- On pix_ce: h increments. At HMAX-1, h wraps to 0 and v increments. At VMAX-1 with h at HMAX-1, v wraps to 0.
- en=0: div, h and v hold. Registered outputs continue to show the held position; pix_valid, line_start and frame_start are 0.
- restart=1: next edge sets div=h=v=0 regardless of en. restart overrides pix_ce.
- Decode from (h, v, div), registered to outputs:
  - hs_act = HACTIVE+HFP <= h < HACTIVE+HFP+HSYN; vs_act likewise on v.
  - hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise.
  - blank_b = de = (h < HACTIVE) & (v < VACTIVE).
  - x=h, y=v; pix_valid = en & (div==0); line_start = pix_valid & (h==0); frame_start = line_start & (v==0).
- Look-ahead: rh = h+LEAD computed at CW+1 bits. If rh >= HMAX: rh -= HMAX and rv = v+1, wrapping VMAX to 0; else rv = v. req_valid = (rh < HACTIVE) & (rv < VACTIVE).

## Timing
- All outputs are registered: they reflect (h, v, div) from the previous edge. Latency is 1 vgaclk from counter state to pins. No combinational path runs from en or restart to any output.
- Reset (reset_n=0, async): div=h=v=0; hsync=~HS_POL; vsync=~VS_POL; sync_b=1; blank_b=de=0; x=y=req_x=req_y=0; req_valid=pix_valid=line_start=frame_start=0.
- First edge after reset release with en=1: outputs show (0,0) with de=1, pix_valid=1, line_start=1, frame_start=1, req=(LEAD,0).
- Frame period: HMAX*VMAX*PIX_DIV vgaclk cycles between frame_start pulses while en stays high. Line period: HMAX*PIX_DIV cycles.
- Reset asserted mid-frame: all outputs take reset values immediately, with no partial sync pulse extension.
- restart and en=0 together: the counters still zero; the first strobes follow on the first edge with en=1.

## Test plan
- Reset then release, default parameters, en=1 -> first clock: frame_start=line_start=de=1, x=y=0, hsync=vsync=1; reset values checked while reset_n=0.
- Default 640x480 run -> hsync low for exactly 96 clocks starting 656 clocks after line_start; 800 clocks between line_start pulses; vsync low for lines 490..491; 420000 clocks between frame_start pulses; de high 640x480 times per frame.
- PIX_DIV=2, HS_POL=1 -> each x value held 2 clocks; pix_valid pulses on alternate clocks; hsync high for 192 clocks; frame period 840000 clocks.
- en dropped for 37 clocks at x=100 -> x stays at 100 and the strobes stay 0; after en returns, the line_start period measures 800+37.
- restart pulsed at (x=300, y=200) -> two edges later outputs show (0,0) with frame_start=1; the following frame_start comes 420000 clocks after that.
- LEAD=4 at h=797, v=524 -> req=(1,0), req_valid=1; at h=630, v=10 -> req=(634,10), req_valid=1; at h=637 -> req_valid=0.
